// File: rtl/bsr_sched_pkg.sv
// Shared types for the BSR load scheduler: FSM states, error codes and the
// {layer, bank} tag carried through the ready FIFO.
package bsr_sched_pkg;

  // Widest layer index a tag can carry; the top narrows it to LAYER_W.
  localparam int LAYER_W_MAX = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BANK,
    ISSUE,
    LOAD,
    ABORT,
    DRAIN,
    FAIL
  } sched_state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RETRY = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_REL   = 2'd3;

  typedef struct packed {
    logic [LAYER_W_MAX-1:0] layer;
    logic                   bank;
  } bank_tag_t;

endpackage

// File: rtl/bsr_sched_fifo2.sv
// Two-entry FIFO of loaded-bank tags offered to compute; entry0 is the head.
// Push and pop in the same cycle are allowed.
module bsr_sched_fifo2
  import bsr_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [LAYER_W_MAX-1:0] push_layer,
  input  logic                   push_bank,
  input  logic                   pop_ready,
  output logic                   valid,
  output logic [LAYER_W_MAX-1:0] head_layer,
  output logic                   head_bank,
  output logic [1:0]             banks_held
);

  bank_tag_t  entry0;
  bank_tag_t  entry1;
  bank_tag_t  in_tag;
  logic [1:0] count;
  logic       pop;

  assign in_tag     = '{layer: push_layer, bank: push_bank};
  assign valid      = (count != 2'd0);
  assign pop        = valid && pop_ready;
  assign head_layer = entry0.layer;
  assign head_bank  = entry0.bank;

  // Which banks are still queued; a release of such a bank is illegal.
  always_comb begin
    banks_held = 2'b00;
    if (count != 2'd0) banks_held[entry0.bank] = 1'b1;
    if (count == 2'd2) banks_held[entry1.bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            entry0 <= in_tag;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            entry0 <= in_tag;
          end else if (push) begin
            entry1 <= in_tag;
            count  <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (push && pop) begin
            entry0 <= entry1;
            entry1 <= in_tag;
          end else if (pop) begin
            entry0 <= entry1;
            count  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/bsr_load_sched.sv
// Per-layer DMA load sequencer feeding a ping-pong BSR weight buffer, with
// retry on DMA error/timeout and bank recycling on compute release.
module bsr_load_sched
  import bsr_sched_pkg::*;
#(
  parameter int LAYER_W = 3,
  parameter int RETRY_W = 3,
  parameter int TMO_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W:0]   num_layers,
  input  logic [RETRY_W-1:0] max_retries,
  input  logic [TMO_W-1:0]   timeout_cycles,
  output logic               dma_start,
  output logic [LAYER_W-1:0] dma_layer,
  output logic               dma_bank,
  output logic               dma_abort,
  input  logic               dma_busy,
  input  logic               dma_done,
  input  logic               dma_error,
  output logic               cmp_valid,
  output logic [LAYER_W-1:0] cmp_layer,
  output logic               cmp_bank,
  input  logic               cmp_ready,
  input  logic               cmp_release,
  input  logic               cmp_release_bank,
  output logic               sched_busy,
  output logic               sched_done,
  output logic               sched_error,
  output logic [1:0]         err_code,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LAYER_W:0]   layers_loaded
);

  sched_state_t           state;
  logic                   wr_bank;
  logic [1:0]             bank_full;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   fifo_push;
  logic [LAYER_W_MAX-1:0] fifo_head_layer;
  logic [1:0]             banks_held;
  logic                   tmo_hit;
  logic                   last_layer;
  logic                   rel_bad;

  assign fifo_push  = (state == LOAD) && dma_done;
  assign tmo_hit    = (timeout_cycles != '0) && (tmo_cnt == timeout_cycles - 1'b1);
  assign last_layer = ((layers_loaded + 1'b1) == num_layers);
  assign rel_bad    = !bank_full[cmp_release_bank] || banks_held[cmp_release_bank];
  assign cmp_layer  = fifo_head_layer[LAYER_W-1:0];

  bsr_sched_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_layer (LAYER_W_MAX'(dma_layer)),
    .push_bank  (dma_bank),
    .pop_ready  (cmp_ready),
    .valid      (cmp_valid),
    .head_layer (fifo_head_layer),
    .head_bank  (cmp_bank),
    .banks_held (banks_held)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_bank       <= 1'b0;
      bank_full     <= 2'b00;
      tmo_cnt       <= '0;
      dma_start     <= 1'b0;
      dma_layer     <= '0;
      dma_bank      <= 1'b0;
      dma_abort     <= 1'b0;
      sched_busy    <= 1'b0;
      sched_done    <= 1'b0;
      sched_error   <= 1'b0;
      err_code      <= ERR_NONE;
      retry_cnt     <= '0;
      layers_loaded <= '0;
    end else begin
      dma_start  <= 1'b0;
      dma_abort  <= 1'b0;
      sched_done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            layers_loaded <= '0;
            retry_cnt     <= '0;
            sched_error   <= 1'b0;
            err_code      <= ERR_NONE;
            if (num_layers == '0) begin
              sched_done <= 1'b1;
            end else begin
              sched_busy <= 1'b1;
              state      <= WAIT_BANK;
            end
          end
        end
        WAIT_BANK: begin
          if (!bank_full[wr_bank]) begin
            dma_start <= 1'b1;
            dma_layer <= layers_loaded[LAYER_W-1:0];
            dma_bank  <= wr_bank;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= LOAD;
        end
        LOAD: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (dma_done) begin
            wr_bank       <= ~wr_bank;
            layers_loaded <= layers_loaded + 1'b1;
            retry_cnt     <= '0;
            state         <= last_layer ? DRAIN : WAIT_BANK;
          end else if (dma_error || tmo_hit) begin
            if (retry_cnt < max_retries) begin
              retry_cnt <= retry_cnt + 1'b1;
              dma_abort <= !dma_error;
              state     <= ABORT;
            end else begin
              sched_error <= 1'b1;
              sched_busy  <= 1'b0;
              err_code    <= dma_error ? ERR_RETRY : ERR_TMO;
              state       <= FAIL;
            end
          end
        end
        ABORT: begin
          // Reissue the same layer into the same bank once the DMA is quiet.
          if (!dma_busy) begin
            dma_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        DRAIN: begin
          if (bank_full == 2'b00 && !cmp_valid) begin
            sched_done <= 1'b1;
            sched_busy <= 1'b0;
            state      <= IDLE;
          end
        end
        FAIL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (fifo_push) bank_full[wr_bank] <= 1'b1;

      // Releases are serviced in every state, including after a failure.
      if (cmp_release) begin
        if (rel_bad) begin
          sched_error <= 1'b1;
          err_code    <= ERR_REL;
        end else begin
          bank_full[cmp_release_bank] <= 1'b0;
        end
      end
    end
  end

endmodule
